pipe_register_chain: RTL and testbench



---
 rtl/pipe_register_chain.sv | 124 ++++++++++++
 tb/tb_pipe_register_chain.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_register_chain.sv
// WIDTH-bit, DEPTH-stage valid/ready register pipeline built from 2-entry skid stages.
// Define PIPE_REG_CHAIN_OCCUPANCY_EN to add a registered occupancy count output.
module pipe_register_chain #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data
`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
    ,
    output logic [$clog2(2*DEPTH+1)-1:0] occupancy
`endif
);

    logic [DEPTH-1:0] mv_q, mv_d, sv_q, sv_d;
    logic [WIDTH-1:0] md_q [DEPTH];
    logic [WIDTH-1:0] md_d [DEPTH];
    logic [WIDTH-1:0] sd_q [DEPTH];
    logic [WIDTH-1:0] sd_d [DEPTH];

    logic [DEPTH-1:0] up_valid, dn_ready;
    logic [WIDTH-1:0] up_data [DEPTH];

    // Each stage's ready comes only from its own skid flag, so no comb path spans stages.
    always_comb begin
        up_valid[0] = in_valid;
        up_data[0]  = in_data;
        for (int k = 1; k < int'(DEPTH); k++) begin
            up_valid[k] = mv_q[k-1];
            up_data[k]  = md_q[k-1];
        end
        for (int k = 0; k < int'(DEPTH) - 1; k++) begin
            dn_ready[k] = !sv_q[k+1];
        end
        dn_ready[DEPTH-1] = out_ready;
    end

    always_comb begin
        mv_d = mv_q;
        sv_d = sv_q;
        md_d = md_q;
        sd_d = sd_q;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (flush) begin
                mv_d[k] = 1'b0;
                sv_d[k] = 1'b0;
            end else if (dn_ready[k] || !mv_q[k]) begin
                if (sv_q[k]) begin
                    mv_d[k] = 1'b1;
                    md_d[k] = sd_q[k];
                end else if (up_valid[k]) begin
                    mv_d[k] = 1'b1;
                    md_d[k] = up_data[k];
                end else begin
                    mv_d[k] = 1'b0;
                end
                sv_d[k] = 1'b0;
            end else if (up_valid[k] && !sv_q[k]) begin
                // Head is stalled: park the incoming beat in the skid slot.
                sv_d[k] = 1'b1;
                sd_d[k] = up_data[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv_q <= '0;
            sv_q <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                md_q[k] <= '0;
                sd_q[k] <= '0;
            end
        end else begin
            mv_q <= mv_d;
            sv_q <= sv_d;
            md_q <= md_d;
            sd_q <= sd_d;
        end
    end

    assign in_ready  = !sv_q[0] && !flush;
    assign out_valid = mv_q[DEPTH-1];
    assign out_data  = md_q[DEPTH-1];

`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
    localparam int unsigned OccW = $clog2(2*DEPTH+1);

    logic            in_fire, out_fire;
    logic [OccW-1:0] occ_q, occ_d;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_fire && !out_fire) begin
            occ_d = occ_q + 1'b1;
        end else if (!in_fire && out_fire) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_pipe_register_chain.sv
// Scoreboard bench for pipe_register_chain (WIDTH=8, DEPTH=3): driver pushes accepted beats,
// a separate monitor pops and compares every delivered beat.
module tb_pipe_register_chain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
    logic [$clog2(2*DEPTH+1)-1:0] occupancy;
`endif

    pipe_register_chain #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
        ,
        .occupancy(occupancy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               acc_cyc;
    } beat_t;

    beat_t sb[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;
    int    n_pop = 0;
    bit    lat_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: observes the output interface mid-cycle, ahead of the next edge.
    bit               holding = 1'b0;
    logic [WIDTH-1:0] held;
    int               first_cyc = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (!holding) first_cyc = cyc;
                else check("out_data_stable", out_data, held);
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        check("spurious_beat", out_valid, 0);
                    end else begin
                        beat_t b;
                        b = sb.pop_front();
                        n_pop++;
                        check("out_data_order", out_data, b.data);
                        if (lat_chk) check("latency", first_cyc - b.acc_cyc, DEPTH - 1);
                    end
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    held    = out_data;
                end
            end else begin
                holding = 1'b0;
            end
        end
    end

    // One clock: record acceptance at mid-cycle, return just after the next edge.
    task automatic cycle(output bit acc);
        beat_t b;
        @(negedge clk);
        acc = (in_valid && in_ready && rst_n);
        if (acc) begin
            b.data    = in_data;
            b.acc_cyc = cyc + 1;
            sb.push_back(b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(a);
    endtask

    // Present one beat until accepted, bounded.
    task automatic send(input logic [WIDTH-1:0] d);
        bit a = 1'b0;
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!a && t < 50) begin
            cycle(a);
            t++;
        end
        in_valid = 1'b0;
        if (!a) check("send_timeout", a, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int acc_n;
        int idx;
        int pop0;
        int t;

        // Reset hold and release
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        idle(1);
        check("rel_in_ready", in_ready, 1);
        check("rel_out_valid", out_valid, 0);
        check("rel_out_data", out_data, 0);
`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
        check("rel_occupancy", occupancy, 0);
`endif

        // Back-to-back stream, no backpressure
        lat_chk = 1'b1;
        pop0 = n_pop;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(i);
            check("stream_in_ready", in_ready, 1);
            cycle(acc);
        end
        in_valid = 1'b0;
        idle(8);
        lat_chk = 1'b0;
        check("stream_count", n_pop - pop0, 10);
        check("stream_drained", sb.size(), 0);

        // Full backpressure: capacity is exactly 2*DEPTH
        out_ready = 1'b0;
        pop0 = n_pop;
        idx = 'h10;
        acc_n = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = 1'b1;
            in_data  = idx[WIDTH-1:0];
            cycle(acc);
            if (acc) begin
                idx++;
                acc_n++;
            end
        end
        check("full_accepted", acc_n, 2 * DEPTH);
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        check("full_out_data", out_data, 'h10);
`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
        check("full_occupancy", occupancy, 2 * DEPTH);
`endif
        out_ready = 1'b1;
        t = 0;
        while (idx <= 'h17 && t < 30) begin
            in_valid = 1'b1;
            in_data  = idx[WIDTH-1:0];
            cycle(acc);
            if (acc) idx++;
            t++;
        end
        in_valid = 1'b0;
        idle(12);
        check("bp_count", n_pop - pop0, 8);
        check("bp_drained", sb.size(), 0);

        // Randomised valid/ready over 1000 beats
        acc_n = 0;
        t = 0;
        while (acc_n < 1000 && t < 20000) begin
            in_valid  = $urandom_range(0, 1);
            in_data   = WIDTH'($urandom);
            out_ready = $urandom_range(0, 1);
            cycle(acc);
            if (acc) acc_n++;
            t++;
`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
            if (t % 50 == 0) check("rand_occupancy", occupancy, sb.size());
`endif
        end
        check("rand_beats", acc_n, 1000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(15);
        check("rand_drained", sb.size(), 0);

        // Flush with a beat offered: nothing stored or offered survives
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(WIDTH'('h21 + i));
        in_valid = 1'b1;
        in_data  = 'hAA;
        flush    = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 0);
        cycle(acc);
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("flush_out_valid", out_valid, 0);
`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
        check("flush_occupancy", occupancy, 0);
`endif
        out_ready = 1'b1;
        lat_chk = 1'b1;
        pop0 = n_pop;
        send('h55);
        idle(6);
        lat_chk = 1'b0;
        check("post_flush_count", n_pop - pop0, 1);

        // Asynchronous reset in the middle of a cycle
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(WIDTH'('h31 + i));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_data", out_data, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(acc);
            check("no_stale_beat", out_valid, 0);
        end
        lat_chk = 1'b1;
        pop0 = n_pop;
        send('h77);
        idle(6);
        lat_chk = 1'b0;
        check("post_reset_count", n_pop - pop0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
